// File: rtl/tl_source_downsizer.sv
// TileLink source-ID downsizer: remaps wide host source IDs onto a small
// pool of device source IDs and restores the host ID on the response path.
//
// Channel payloads are flat packed vectors, source field in the LSBs:
//   A: {opcode[2:0], param[2:0], size, address, mask, data, corrupt, source}
//   B: {opcode[2:0], param[1:0], size, source, address, mask, data, corrupt}
//   C: {opcode[2:0], param[2:0], size, source, address, data, corrupt}
//   D: {opcode[2:0], param[1:0], size, sink, denied, data, corrupt, source}
//   E: {sink}
module tl_source_downsizer #(
  parameter int unsigned HostSourceWidth   = 8,
  parameter int unsigned DeviceSourceWidth = 2,
  parameter int unsigned SinkWidth         = 1,
  parameter int unsigned AddrWidth         = 56,
  parameter int unsigned DataWidth         = 64,
  localparam int unsigned SizeWidth   = 4,
  localparam int unsigned MaskWidth   = DataWidth / 8,
  localparam int unsigned AHostWidth  = 3 + 3 + SizeWidth + AddrWidth + MaskWidth + DataWidth + 1 + HostSourceWidth,
  localparam int unsigned ADevWidth   = 3 + 3 + SizeWidth + AddrWidth + MaskWidth + DataWidth + 1 + DeviceSourceWidth,
  localparam int unsigned BHostWidth  = 3 + 2 + SizeWidth + HostSourceWidth + AddrWidth + MaskWidth + DataWidth + 1,
  localparam int unsigned BDevWidth   = 3 + 2 + SizeWidth + DeviceSourceWidth + AddrWidth + MaskWidth + DataWidth + 1,
  localparam int unsigned CHostWidth  = 3 + 3 + SizeWidth + HostSourceWidth + AddrWidth + DataWidth + 1,
  localparam int unsigned CDevWidth   = 3 + 3 + SizeWidth + DeviceSourceWidth + AddrWidth + DataWidth + 1,
  localparam int unsigned DHostWidth  = 3 + 2 + SizeWidth + SinkWidth + 1 + DataWidth + 1 + HostSourceWidth,
  localparam int unsigned DDevWidth   = 3 + 2 + SizeWidth + SinkWidth + 1 + DataWidth + 1 + DeviceSourceWidth,
  localparam int unsigned EWidth      = SinkWidth
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,

  input  logic                  host_a_valid,
  output logic                  host_a_ready,
  input  logic [AHostWidth-1:0] host_a,
  output logic                  host_b_valid,
  input  logic                  host_b_ready,
  output logic [BHostWidth-1:0] host_b,
  input  logic                  host_c_valid,
  output logic                  host_c_ready,
  input  logic [CHostWidth-1:0] host_c,
  output logic                  host_d_valid,
  input  logic                  host_d_ready,
  output logic [DHostWidth-1:0] host_d,
  input  logic                  host_e_valid,
  output logic                  host_e_ready,
  input  logic [EWidth-1:0]     host_e,

  output logic                  device_a_valid,
  input  logic                  device_a_ready,
  output logic [ADevWidth-1:0]  device_a,
  input  logic                  device_b_valid,
  output logic                  device_b_ready,
  input  logic [BDevWidth-1:0]  device_b,
  output logic                  device_c_valid,
  input  logic                  device_c_ready,
  output logic [CDevWidth-1:0]  device_c,
  input  logic                  device_d_valid,
  output logic                  device_d_ready,
  input  logic [DDevWidth-1:0]  device_d,
  output logic                  device_e_valid,
  input  logic                  device_e_ready,
  output logic [EWidth-1:0]     device_e
);

  localparam int unsigned NumIds       = 2 ** DeviceSourceWidth;
  localparam int unsigned LgBeatBytes  = $clog2(MaskWidth);
  localparam int unsigned CntRaw       = (2 ** SizeWidth - 1) - LgBeatBytes;
  localparam int unsigned CntWidth     = (CntRaw > 0) ? CntRaw : 1;

  localparam logic [2:0] OpPutFullData    = 3'd0;
  localparam logic [2:0] OpPutPartialData = 3'd1;
  localparam logic [2:0] OpAccessAckData  = 3'd1;

  // Number of beats minus one for a message of the given size.
  function automatic logic [CntWidth-1:0] beats_m1(input logic [SizeWidth-1:0] size,
                                                    input logic               burst);
    logic [CntWidth:0] one_hot;
    one_hot  = '0;
    beats_m1 = '0;
    if (burst && (size > SizeWidth'(LgBeatBytes))) begin
      one_hot  = (CntWidth+1)'(1) << (size - SizeWidth'(LgBeatBytes));
      beats_m1 = CntWidth'(one_hot - (CntWidth+1)'(1));
    end
  endfunction

  logic [NumIds-1:0]          busy_q, busy_d;
  logic [HostSourceWidth-1:0] src_q [NumIds];
  logic [CntWidth-1:0]        a_cnt_q, a_cnt_d;
  logic [CntWidth-1:0]        d_cnt_q, d_cnt_d;
  logic [DeviceSourceWidth-1:0] a_id_q, a_id_d;

  logic [2:0]                   a_opcode;
  logic [SizeWidth-1:0]         a_size;
  logic [HostSourceWidth-1:0]   a_source;
  logic [2:0]                   d_opcode;
  logic [SizeWidth-1:0]         d_size;
  logic [DeviceSourceWidth-1:0] d_idx;

  logic [DeviceSourceWidth-1:0] free_id;
  logic                         all_busy;
  logic [DeviceSourceWidth-1:0] a_id;
  logic                         a_first, a_stall, a_fire, a_last;
  logic                         d_fire, d_last;
  logic [CntWidth-1:0]          a_beats_m1, d_beats_m1;

  assign a_opcode = host_a[AHostWidth-1 -: 3];
  assign a_size   = host_a[AHostWidth-7 -: SizeWidth];
  assign a_source = host_a[HostSourceWidth-1:0];
  assign d_opcode = device_d[DDevWidth-1 -: 3];
  assign d_size   = device_d[DDevWidth-6 -: SizeWidth];
  assign d_idx    = device_d[DeviceSourceWidth-1:0];

  // Lowest-index free entry, judged on registered busy bits only, so an entry
  // freed this cycle becomes eligible on the next one.
  always_comb begin
    free_id  = '0;
    all_busy = &busy_q;
    for (int i = NumIds - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_id = DeviceSourceWidth'(i);
    end
  end

  assign a_beats_m1 = beats_m1(a_size, (a_opcode == OpPutFullData) || (a_opcode == OpPutPartialData));
  assign d_beats_m1 = beats_m1(d_size, d_opcode == OpAccessAckData);

  assign a_first = (a_cnt_q == '0);
  assign a_id    = a_first ? free_id : a_id_q;
  assign a_stall = a_first & all_busy;
  assign a_fire  = host_a_valid & host_a_ready;
  assign a_last  = (a_cnt_q == a_beats_m1);
  assign d_fire  = device_d_valid & host_d_ready;
  assign d_last  = (d_cnt_q == d_beats_m1);

  // A path: pass-through with the source field swapped for the allocated ID.
  assign device_a_valid = host_a_valid & ~a_stall;
  assign host_a_ready   = device_a_ready & ~a_stall;
  assign device_a       = {host_a[AHostWidth-1:HostSourceWidth], a_id};

  // D path: pass-through with the original host source restored.
  assign host_d_valid   = device_d_valid;
  assign device_d_ready = host_d_ready;
  assign host_d         = {device_d[DDevWidth-1:DeviceSourceWidth], src_q[d_idx]};

  // Unused channels are parked.
  assign host_b_valid   = 1'b0;
  assign host_b         = '0;
  assign device_b_ready = 1'b1;
  assign host_c_ready   = 1'b1;
  assign device_c_valid = 1'b0;
  assign device_c       = '0;
  assign host_e_ready   = 1'b1;
  assign device_e_valid = 1'b0;
  assign device_e       = '0;

  logic unused_inputs;
  assign unused_inputs = ^{host_b_ready, host_c_valid, host_c, host_e_valid, host_e,
                           device_b_valid, device_b, device_c_ready, device_e_ready};

  // Next-state for the busy table, beat counters and held burst ID.
  always_comb begin
    busy_d  = busy_q;
    a_cnt_d = a_cnt_q;
    d_cnt_d = d_cnt_q;
    a_id_d  = a_id_q;
    if (d_fire) begin
      d_cnt_d = d_last ? '0 : d_cnt_q + CntWidth'(1);
      if (d_last) busy_d[d_idx] = 1'b0;
    end
    if (a_fire) begin
      a_cnt_d = a_last ? '0 : a_cnt_q + CntWidth'(1);
      if (a_first) begin
        busy_d[free_id] = 1'b1;
        a_id_d          = free_id;
      end
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      busy_q  <= '0;
      a_cnt_q <= '0;
      d_cnt_q <= '0;
      a_id_q  <= '0;
    end else begin
      busy_q  <= busy_d;
      a_cnt_q <= a_cnt_d;
      d_cnt_q <= d_cnt_d;
      a_id_q  <= a_id_d;
    end
  end

  // Host source capture on each allocation; qualified by busy, so no reset.
  always_ff @(posedge clk_i) begin
    if (a_fire && a_first) src_q[free_id] <= a_source;
  end

  // A response on an entry that was never allocated has no source to restore.
  d_targets_busy_entry: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                         device_d_valid |-> busy_q[d_idx]);

endmodule

// File: tb/tb_tl_source_downsizer.sv
// Scoreboard bench for tl_source_downsizer: expected device-A and host-D
// beats are queued when driven and compared when the handshake occurs.
module tb_tl_source_downsizer;

  localparam int unsigned HSW = 8;
  localparam int unsigned DSW = 2;
  localparam int unsigned AHW = 3 + 3 + 4 + 56 + 8 + 64 + 1 + HSW;
  localparam int unsigned ADW = 3 + 3 + 4 + 56 + 8 + 64 + 1 + DSW;
  localparam int unsigned BHW = 3 + 2 + 4 + HSW + 56 + 8 + 64 + 1;
  localparam int unsigned BDW = 3 + 2 + 4 + DSW + 56 + 8 + 64 + 1;
  localparam int unsigned CHW = 3 + 3 + 4 + HSW + 56 + 64 + 1;
  localparam int unsigned CDW = 3 + 3 + 4 + DSW + 56 + 64 + 1;
  localparam int unsigned DHW = 3 + 2 + 4 + 1 + 1 + 64 + 1 + HSW;
  localparam int unsigned DDW = 3 + 2 + 4 + 1 + 1 + 64 + 1 + DSW;

  localparam logic [2:0] OpPutFull  = 3'd0;
  localparam logic [2:0] OpGet      = 3'd4;
  localparam logic [2:0] OpAck      = 3'd0;
  localparam logic [2:0] OpAckData  = 3'd1;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;

  logic           host_a_valid = 1'b0, host_a_ready;
  logic [AHW-1:0] host_a = '0;
  logic           host_b_valid, host_b_ready = 1'b1;
  logic [BHW-1:0] host_b;
  logic           host_c_valid = 1'b0, host_c_ready;
  logic [CHW-1:0] host_c = '0;
  logic           host_d_valid, host_d_ready = 1'b1;
  logic [DHW-1:0] host_d;
  logic           host_e_valid = 1'b0, host_e_ready;
  logic [0:0]     host_e = '0;
  logic           device_a_valid, device_a_ready = 1'b1;
  logic [ADW-1:0] device_a;
  logic           device_b_valid = 1'b0, device_b_ready;
  logic [BDW-1:0] device_b = '0;
  logic           device_c_valid, device_c_ready = 1'b1;
  logic [CDW-1:0] device_c;
  logic           device_d_valid = 1'b0, device_d_ready;
  logic [DDW-1:0] device_d = '0;
  logic           device_e_valid, device_e_ready = 1'b1;
  logic [0:0]     device_e;

  tl_source_downsizer dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .host_a_valid(host_a_valid), .host_a_ready(host_a_ready), .host_a(host_a),
    .host_b_valid(host_b_valid), .host_b_ready(host_b_ready), .host_b(host_b),
    .host_c_valid(host_c_valid), .host_c_ready(host_c_ready), .host_c(host_c),
    .host_d_valid(host_d_valid), .host_d_ready(host_d_ready), .host_d(host_d),
    .host_e_valid(host_e_valid), .host_e_ready(host_e_ready), .host_e(host_e),
    .device_a_valid(device_a_valid), .device_a_ready(device_a_ready), .device_a(device_a),
    .device_b_valid(device_b_valid), .device_b_ready(device_b_ready), .device_b(device_b),
    .device_c_valid(device_c_valid), .device_c_ready(device_c_ready), .device_c(device_c),
    .device_d_valid(device_d_valid), .device_d_ready(device_d_ready), .device_d(device_d),
    .device_e_valid(device_e_valid), .device_e_ready(device_e_ready), .device_e(device_e)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_a_cyc = 0;
  int last_d_cyc = 0;

  logic [ADW-1:0] a_q[$];
  logic [DHW-1:0] d_q[$];

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [AHW-1:0] mk_a(input logic [2:0] op, input logic [3:0] size,
                                          input logic [7:0] src, input logic [63:0] data);
    return {op, 3'b000, size, 56'h8000_1000, 8'hFF, data, 1'b0, src};
  endfunction

  function automatic logic [DDW-1:0] mk_d(input logic [2:0] op, input logic [3:0] size,
                                          input logic [1:0] id, input logic [63:0] data);
    return {op, 2'b00, size, 1'b0, 1'b0, data, 1'b0, id};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: compare every handshaken beat against the queued expectation.
  always @(negedge clk) begin
    if (rst_ni) begin
      if (device_a_valid && device_a_ready) begin
        last_a_cyc = cyc;
        if (a_q.size() == 0) check("a_unexpected_beat", 1, 0);
        else check("device_a_beat", device_a, a_q.pop_front());
      end
      if (host_d_valid && host_d_ready) begin
        last_d_cyc = cyc;
        if (d_q.size() == 0) check("d_unexpected_beat", 1, 0);
        else check("host_d_beat", host_d, d_q.pop_front());
      end
    end
  end

  task automatic a_beat(input logic [AHW-1:0] pl, input logic [DSW-1:0] id, input bit toggle);
    logic [AHW-1:0] p;
    p = pl;
    a_q.push_back({p[AHW-1:HSW], id});
    host_a = p;
    host_a_valid = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (toggle) device_a_ready = ~device_a_ready;
      @(negedge clk);
      if (host_a_ready) begin
        @(posedge clk); #1;
        host_a_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    check("a_handshake_timeout", 0, 1);
    host_a_valid = 1'b0;
  endtask

  task automatic a_burst(input logic [2:0] op, input logic [3:0] size, input logic [7:0] src,
                         input logic [DSW-1:0] id, input int beats, input bit toggle);
    for (int b = 0; b < beats; b++) a_beat(mk_a(op, size, src, 64'(b) + 64'h100), id, toggle);
  endtask

  task automatic d_beat(input logic [2:0] op, input logic [3:0] size, input logic [DSW-1:0] id,
                        input logic [63:0] data, input logic [HSW-1:0] exp_src);
    logic [DDW-1:0] p;
    p = mk_d(op, size, id, data);
    d_q.push_back({p[DDW-1:DSW], exp_src});
    device_d = p;
    device_d_valid = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (device_d_ready) begin
        @(posedge clk); #1;
        device_d_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    check("d_handshake_timeout", 0, 1);
    device_d_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    // Reset: outputs follow the cleared table, offering ID 0.
    @(posedge clk); #1;
    host_a = mk_a(OpGet, 4'd3, 8'h33, 64'h0);
    host_a_valid = 1'b1;
    @(negedge clk);
    check("rst_dev_a_valid", device_a_valid, 1);
    check("rst_dev_a_source", device_a[DSW-1:0], 0);
    check("rst_host_a_ready", host_a_ready, 1);
    check("tieoffs", {host_b_valid, device_b_ready, host_c_ready, device_c_valid,
                      host_e_ready, device_e_valid}, 6'b011010);
    @(posedge clk); #1;
    device_a_ready = 1'b0;
    @(negedge clk);
    check("rst_host_a_ready_follow", host_a_ready, 0);
    @(posedge clk); #1;
    host_a_valid = 1'b0;
    device_a_ready = 1'b1;
    rst_ni = 1'b1;

    // Single Get and its response.
    a_beat(mk_a(OpGet, 4'd3, 8'hA5, 64'h0), 2'd0, 1'b0);
    d_beat(OpAckData, 4'd3, 2'd0, 64'hDEAD, 8'hA5);

    // Fill the table, then a fifth Get waits for a completion.
    for (int i = 0; i < 4; i++) a_beat(mk_a(OpGet, 4'd3, 8'(i + 1), 64'h0), DSW'(i), 1'b0);
    fork
      a_beat(mk_a(OpGet, 4'd3, 8'h05, 64'h0), 2'd1, 1'b0);
      begin
        repeat (3) begin
          @(negedge clk);
          check("full_stall", {host_a_ready, device_a_valid}, 2'b00);
        end
        @(posedge clk); #1;
        d_beat(OpAckData, 4'd3, 2'd1, 64'h11, 8'h02);
      end
    join
    d_beat(OpAckData, 4'd3, 2'd0, 64'h20, 8'h01);
    d_beat(OpAckData, 4'd3, 2'd2, 64'h22, 8'h03);
    d_beat(OpAckData, 4'd3, 2'd3, 64'h23, 8'h04);
    d_beat(OpAckData, 4'd3, 2'd1, 64'h21, 8'h05);

    // Four-beat PutFullData under a toggling ready keeps one ID.
    a_burst(OpPutFull, 4'd5, 8'h30, 2'd0, 4, 1'b1);
    device_a_ready = 1'b1;
    a_beat(mk_a(OpGet, 4'd3, 8'h31, 64'h0), 2'd1, 1'b0);
    d_beat(OpAck, 4'd5, 2'd0, 64'h0, 8'h30);
    d_beat(OpAckData, 4'd3, 2'd1, 64'h31, 8'h31);

    // Four-beat AccessAckData frees its entry only after the last beat.
    a_beat(mk_a(OpGet, 4'd5, 8'h40, 64'h0), 2'd0, 1'b0);
    for (int i = 1; i < 4; i++) a_beat(mk_a(OpGet, 4'd3, 8'(8'h40 + i), 64'h0), DSW'(i), 1'b0);
    fork
      a_beat(mk_a(OpGet, 4'd3, 8'h50, 64'h0), 2'd0, 1'b0);
      for (int b = 0; b < 4; b++) d_beat(OpAckData, 4'd5, 2'd0, 64'(b), 8'h40);
    join
    check("d4_realloc_next_cycle", last_a_cyc, last_d_cyc + 1);

    // Last D beat on ID 2 coincides with an A request on a full table.
    fork
      a_beat(mk_a(OpGet, 4'd3, 8'h60, 64'h0), 2'd2, 1'b0);
      d_beat(OpAckData, 4'd3, 2'd2, 64'h42, 8'h42);
    join
    check("same_cycle_free_realloc", last_a_cyc, last_d_cyc + 1);
    d_beat(OpAckData, 4'd3, 2'd0, 64'h50, 8'h50);
    d_beat(OpAckData, 4'd3, 2'd1, 64'h41, 8'h41);
    d_beat(OpAckData, 4'd3, 2'd3, 64'h43, 8'h43);
    d_beat(OpAckData, 4'd3, 2'd2, 64'h60, 8'h60);

    // Reset in the middle of a burst clears the table and counters.
    a_beat(mk_a(OpGet, 4'd3, 8'h21, 64'h0), 2'd0, 1'b0);
    a_burst(OpPutFull, 4'd5, 8'h22, 2'd1, 2, 1'b0);
    rst_ni = 1'b0;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    a_beat(mk_a(OpGet, 4'd3, 8'h23, 64'h0), 2'd0, 1'b0);
    a_beat(mk_a(OpGet, 4'd3, 8'h24, 64'h0), 2'd1, 1'b0);
    d_beat(OpAckData, 4'd3, 2'd0, 64'h23, 8'h23);
    d_beat(OpAckData, 4'd3, 2'd1, 64'h24, 8'h24);

    repeat (2) @(posedge clk);
    check("a_queue_drained", a_q.size(), 0);
    check("d_queue_drained", d_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
